// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - command-to-instruction encoder with 4-deep output FIFO
// Illegal commands are consumed and counted; legal ones are queued in order.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [1:0]  in_ri,
  input  logic [1:0]  in_rj,
  input  logic [7:0]  in_func,
  input  logic [11:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_instr,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t      st;
  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        legal;
  logic [15:0] enc;
  logic        accept;
  logic        push;
  logic        pop;

  // ALU func[6:0] must be zero or one-hot; x & (x-1) clears the lowest set bit
  always_comb begin
    legal = 1'b0;
    enc   = 16'h0000;
    case (in_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0100: begin
        legal = 1'b1;
        enc   = {in_op, in_data};
      end
      4'b1000: begin
        legal = ((in_func[6:0] & (in_func[6:0] - 7'd1)) == 7'd0);
        enc   = {in_op, in_ri, in_rj, in_func};
      end
      4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        legal = 1'b1;
        enc   = {in_op, in_ri, in_data[9:0]};
      end
      default: begin
        legal = 1'b0;
        enc   = 16'h0000;
      end
    endcase
  end

  assign in_ready  = (st == RUN) && (count != 3'd4) && !flush;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = (count != 3'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr] : 16'h0000;
  assign state     = st;

  // Storage needs no reset: it is only visible through out_instr while count > 0
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= accept && !legal;
      if (accept && !legal && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (flush) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
        count  <= 3'd0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 2'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
        case ({push, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end

      case (st)
        IDLE: begin
          if (enable) begin
            st <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            st <= (count != 3'd0) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (enable) begin
            st <= RUN;
          end else if (count == 3'd0) begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [1:0]  in_ri = 2'd0;
  logic [1:0]  in_rj = 2'd0;
  logic [7:0]  in_func = 8'd0;
  logic [11:0] in_data = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic        err;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  int n_chk = 0;
  int n_fail = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_ri(in_ri),
    .in_rj(in_rj), .in_func(in_func), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input logic [3:0] op, input logic [7:0] func);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd12, 4'd13, 4'd14, 4'd15: return 1'b1;
      4'd8: return ($countones(func[6:0]) <= 1);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] m_word(input logic [3:0] op, input logic [1:0] ri,
                                         input logic [1:0] rj, input logic [7:0] func,
                                         input logic [11:0] data);
    if (op == 4'd8) return {op, ri, rj, func};
    else if (op[3]) return {op, ri, data[9:0]};
    else return {op, data};
  endfunction

  // Reference model: queue of encoded words plus state, error pulse and counter
  logic [15:0] mq[$];
  int m_state = 0;
  bit m_err = 1'b0;
  int m_cnt = 0;
  bit m_acc;
  int m_sz;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_state = 0;
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      m_sz = mq.size();
      m_acc = in_valid && (m_state == 1) && (m_sz < 4) && !flush;
      m_err = m_acc && !m_legal(in_op, in_func);
      if (m_err && m_cnt < 255) m_cnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_sz > 0 && out_ready) void'(mq.pop_front());
        if (m_acc && m_legal(in_op, in_func))
          mq.push_back(m_word(in_op, in_ri, in_rj, in_func, in_data));
      end
      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = (m_sz > 0) ? 2 : 0;
        2: if (enable) m_state = 1; else if (m_sz == 0) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("state", int'(state), m_state);
      chk("out_valid", int'(out_valid), int'(mq.size() > 0));
      if (mq.size() > 0) chk("out_instr", int'(out_instr), int'(mq[0]));
      chk("in_ready", int'(in_ready), int'((m_state == 1) && (mq.size() < 4) && !flush));
      chk("err", int'(err), int'(m_err));
      chk("err_cnt", int'(err_cnt), m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [1:0] ri, input logic [1:0] rj,
                      input logic [7:0] func, input logic [11:0] data);
    bit ok;
    ok = 1'b0;
    in_op = op; in_ri = ri; in_rj = rj; in_func = func; in_data = data;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  initial begin
    int waited;
    repeat (3) tick();
    chk("rst_state", int'(state), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_out_instr", int'(out_instr), 0);
    rst = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    chk("idle_to_run", int'(state), 1);

    // ADDI ri=2 imm=5
    push(4'hC, 2'd2, 2'd0, 8'h00, 12'h005);
    #1;
    chk("addi_valid", int'(out_valid), 1);
    chk("addi_word", int'(out_instr), 16'hC805);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ALU then illegal opcode
    push(4'h8, 2'd1, 2'd3, 8'h84, 12'h000);
    #1;
    chk("alu_word", int'(out_instr), 16'h8784);
    push(4'h3, 2'd0, 2'd0, 8'h00, 12'h000);
    #1;
    chk("illegal_err", int'(err), 1);
    chk("illegal_cnt", int'(err_cnt), 1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("no_second_word", int'(out_valid), 0);

    // ALU func with two bits set is illegal; func[7] alone is legal
    push(4'h8, 2'd0, 2'd0, 8'h03, 12'h000);
    #1;
    chk("alu_bad_cnt", int'(err_cnt), 2);
    out_ready = 1'b0;
    push(4'h8, 2'd2, 2'd1, 8'h80, 12'h000);
    #1;
    chk("alu_f7_word", int'(out_instr), 16'h8980);
    out_ready = 1'b1;
    tick();

    // Fill to four with consumer stalled
    out_ready = 1'b0;
    push(4'h0, 2'd0, 2'd0, 8'h00, 12'h123);
    push(4'h1, 2'd0, 2'd0, 8'h00, 12'h456);
    push(4'h2, 2'd0, 2'd0, 8'h00, 12'hABC);
    push(4'h4, 2'd0, 2'd0, 8'h00, 12'h00F);
    in_op = 4'hF; in_ri = 2'd3; in_data = 12'h3FF; in_valid = 1'b1;
    #1;
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_head", int'(out_instr), 16'h0123);
    out_ready = 1'b1;
    push(4'hF, 2'd3, 2'd0, 8'h00, 12'h3FF);
    repeat (6) tick();
    chk("full_drained", int'(out_valid), 0);

    // Enable drop with three words queued
    out_ready = 1'b0;
    push(4'hD, 2'd1, 2'd0, 8'h00, 12'h0AA);
    push(4'hE, 2'd2, 2'd0, 8'h00, 12'h155);
    push(4'h0, 2'd0, 2'd0, 8'h00, 12'h777);
    enable = 1'b0;
    tick();
    chk("drain_state", int'(state), 2);
    chk("drain_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    waited = 0;
    while (state != 2'd0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("drain_to_idle", int'(state), 0);
    chk("drain_empty", int'(out_valid), 0);
    enable = 1'b1;
    tick();

    // Flush with a command offered
    out_ready = 1'b0;
    push(4'h1, 2'd0, 2'd0, 8'h00, 12'h001);
    push(4'h1, 2'd0, 2'd0, 8'h00, 12'h002);
    flush = 1'b1;
    in_op = 4'h0; in_data = 12'h999; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", int'(in_ready), 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_empty", int'(out_valid), 0);
    chk("flush_err_cnt", int'(err_cnt), 2);
    tick();

    // Saturate the error counter
    in_op = 4'h3; in_valid = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    chk("err_cnt_sat", int'(err_cnt), 255);

    // Asynchronous reset mid-stream
    push(4'h2, 2'd0, 2'd0, 8'h00, 12'h321);
    push(4'h2, 2'd0, 2'd0, 8'h00, 12'h654);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_err_cnt", int'(err_cnt), 0);
    chk("arst_out_instr", int'(out_instr), 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_empty", int'(out_valid), 0);
    tick();
    chk("post_rst_run", int'(state), 1);
    chk("post_rst_still_empty", int'(out_valid), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
